id_pipe_reg: RTL

Parametrised IF/ID pipeline register between the fetch stage and the decoder/register-file in the decode stage. It carries one instruction word plus NCH side channels (next-PC and delay-slot PCs), and adds a valid bit, stall (hold), flush (bubble insertion) and a saturating stall-cycle counter. Hazard and branch logic use the counter to observe back-pressure. It replaces the fixed three-word decode register with a configurable one that can hold and squash.

---
 rtl/id_pipe_reg.sv | 87 ++++++++
 1 files changed

// File: rtl/id_pipe_reg.sv
// IF/ID pipeline register: instruction word plus NCH side channels, with valid, stall, flush and
// saturating stall/flush counters. Define ID_FLUSH_EN to enable flush; otherwise flush is ignored.
module id_pipe_reg #(
    parameter int unsigned       WIDTH = 32,
    parameter int unsigned       NCH   = 2,
    parameter logic [WIDTH-1:0]  NOP   = '0,
    parameter int unsigned       CW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     din_inst,
    input  logic [NCH*WIDTH-1:0] din_side,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     qinst,
    output logic [NCH*WIDTH-1:0] qside,
    output logic [CW-1:0]        stall_cnt,
    output logic [CW-1:0]        flush_cnt
);

    localparam int unsigned SW      = NCH * WIDTH;
    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    logic           valid_q;
    logic [WIDTH-1:0] inst_q;
    logic [SW-1:0]  side_q;
    logic [CW-1:0]  stall_cnt_q;
    logic           flush_act;

`ifdef ID_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            inst_q      <= NOP;
            side_q      <= '0;
            stall_cnt_q <= '0;
        end else if (flush_act) begin
            // Flush beats a simultaneous stall and ends any stall run.
            valid_q     <= 1'b0;
            inst_q      <= NOP;
            side_q      <= '0;
            stall_cnt_q <= '0;
        end else if (stall) begin
            if (valid_q && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
        end else begin
            valid_q     <= in_valid;
            inst_q      <= in_valid ? din_inst : NOP;
            side_q      <= in_valid ? din_side : '0;
            stall_cnt_q <= '0;
        end
    end

`ifdef ID_FLUSH_EN
    logic [CW-1:0] flush_cnt_q;

    // Only flushes that actually squash a valid entry are counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_q <= '0;
        end else if (flush && valid_q && (flush_cnt_q != CntMax)) begin
            flush_cnt_q <= flush_cnt_q + CntOne;
        end
    end

    assign flush_cnt = flush_cnt_q;
`else
    assign flush_cnt = '0;
`endif

    assign out_valid = valid_q;
    assign qinst     = inst_q;
    assign qside     = side_q;
    assign stall_cnt = stall_cnt_q;

endmodule
